// File: rtl/mac_job_sched_pkg.sv
// Shared definitions for the MAC job scheduler: fixed-point format,
// scheduler state encoding and the ReLU helper.
package mac_job_sched_pkg;

    localparam int MAC_N        = 32;
    localparam int MAC_INTBITS  = 12;
    localparam int MAC_FRACBITS = 20;
    localparam int SIGN_BIT     = MAC_N - 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } sched_state_t;

    // Sign-magnitude ReLU: any value with the sign bit set (including -0) becomes 0.
    function automatic logic [MAC_N-1:0] relu(input logic [MAC_N-1:0] v);
        return v[SIGN_BIT] ? '0 : v;
    endfunction

endpackage

// File: rtl/mac_job_sched_rr_arb2.sv
// Two-way round-robin arbiter. The requester that did not win the previous
// grant is preferred; the pointer only moves when a grant is actually issued.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last;

    // Grant selection: favour the requester other than the last winner.
    always_comb begin
        gnt_valid = en & (|req);
        if (last) begin
            gnt_id = req[0] ? 1'b0 : 1'b1;
        end else begin
            gnt_id = req[1] ? 1'b1 : 1'b0;
        end
    end

    // Last-grant pointer; reset to 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 1'b1;
        end else if (gnt_valid) begin
            last <= gnt_id;
        end
    end

endmodule

// File: rtl/mac_job_sched.sv
// Shares one sign-magnitude MAC between two requesters: arbitrates, streams
// S operand pairs from the operand memory into the MAC, then returns the
// ReLU'd accumulator tagged with the owner's ID.
//
// state | meaning
// IDLE  | waiting for a request; arbiter enabled
// FETCH | S cycles of operand reads, MAC cleared on the first one
// DRAIN | 2 cycles: last operand pair enters the MAC, then the sum settles
// DONE  | result strobe and done pulse to the owner
module mac_job_sched
    import mac_job_sched_pkg::*;
#(
    parameter int S        = 8,
    parameter int N        = MAC_N,
    parameter int INTBITS  = MAC_INTBITS,
    parameter int FRACBITS = MAC_FRACBITS,
    parameter int ADDRW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req,
    input  logic [ADDRW-1:0] base0,
    input  logic [ADDRW-1:0] base1,
    output logic [1:0]       done,
    output logic             busy,
    output logic             mem_rd,
    output logic [ADDRW-1:0] mem_addr,
    input  logic [N-1:0]     w_rdata,
    input  logic [N-1:0]     x_rdata,
    output logic             mac_clr,
    output logic             mac_en,
    output logic [N-1:0]     mac_w,
    output logic [N-1:0]     mac_x,
    input  logic [N-1:0]     mac_acc,
    output logic [N-1:0]     res_data,
    output logic             res_valid,
    output logic             res_id
);

    if (S < 1) begin : g_bad_s
        $error("mac_job_sched: S must be at least 1");
    end
    if (N != MAC_N || INTBITS + FRACBITS != N) begin : g_bad_fmt
        $error("mac_job_sched: fixed-point format does not match the package");
    end

    localparam int CNTW = (S > 1) ? $clog2(S) : 1;
    localparam logic [CNTW-1:0] CNT_INIT = CNTW'(S - 1);

    sched_state_t     state, state_nxt;
    logic [CNTW-1:0]  cnt;
    logic [ADDRW-1:0] addr;
    logic             id;
    logic             gnt_valid;
    logic             gnt_id;

    rr_arb2 u_arb (
        .clk       (clk),
        .reset     (reset),
        .en        (state == ST_IDLE),
        .req       (req),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; cnt is a down-counter shared by FETCH and DRAIN.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (gnt_valid) state_nxt = ST_FETCH;
            ST_FETCH: if (cnt == '0) state_nxt = ST_DRAIN;
            ST_DRAIN: if (cnt == '0) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from registered state only, so no input reaches an output.
    always_comb begin
        busy      = 1'b0;
        mem_rd    = 1'b0;
        mem_addr  = '0;
        mac_clr   = 1'b0;
        done      = '0;
        res_valid = 1'b0;
        res_id    = 1'b0;
        case (state)
            ST_FETCH: begin
                busy     = 1'b1;
                mem_rd   = 1'b1;
                mem_addr = addr;
                mac_clr  = (cnt == CNT_INIT);
            end
            ST_DRAIN: busy = 1'b1;
            ST_DONE: begin
                busy      = 1'b1;
                done[id]  = 1'b1;
                res_valid = 1'b1;
                res_id    = id;
            end
            default: ;
        endcase
    end

    // Job context, operand forwarding and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            id       <= 1'b0;
            addr     <= '0;
            cnt      <= '0;
            mac_en   <= 1'b0;
            mac_w    <= '0;
            mac_x    <= '0;
            res_data <= '0;
        end else begin
            if (state == ST_IDLE && gnt_valid) begin
                id   <= gnt_id;
                addr <= gnt_id ? base1 : base0;
                cnt  <= CNT_INIT;
            end else if (state == ST_FETCH) begin
                addr <= addr + ADDRW'(1);
                // One extra DRAIN cycle lets the last product land in mac_acc.
                cnt  <= (cnt == '0) ? CNTW'(1) : cnt - CNTW'(1);
            end else if (state == ST_DRAIN && cnt != '0) begin
                cnt  <= cnt - CNTW'(1);
            end
            mac_en   <= (state == ST_FETCH);
            mac_w    <= (state == ST_FETCH) ? w_rdata : '0;
            mac_x    <= (state == ST_FETCH) ? x_rdata : '0;
            res_data <= (state == ST_DRAIN && cnt == '0) ? relu(mac_acc) : '0;
        end
    end

endmodule
